// File: rtl/instr_loader.sv
// Framed byte-stream loader: length, payload, checksum -> instruction memory writes.
// Keeps the CPU held in reset until a frame has been written and its checksum matched.
module instr_loader #(
    parameter int ADDRESS_WIDTH = 12,
    parameter int DATA_WIDTH    = 8,
    parameter int BASE_ADDR     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [DATA_WIDTH-1:0]    rx_data,
    input  logic                     rx_valid,
    output logic                     rx_ready,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic                     cpu_hold,
    output logic                     busy,
    output logic                     load_done,
    output logic                     load_err,
    output logic [15:0]              bytes_written
);

    localparam logic [ADDRESS_WIDTH-1:0] BASE    = ADDRESS_WIDTH'(BASE_ADDR);
    localparam logic [16:0]              MAX_LEN = 17'((1 << ADDRESS_WIDTH) - BASE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t                   r_state;
    logic [15:0]              r_len;
    logic [DATA_WIDTH-1:0]    r_sum;
    logic [15:0]              r_count;
    logic [ADDRESS_WIDTH-1:0] r_wr_addr;
    logic                     r_mem_we;
    logic [ADDRESS_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0]    r_mem_wdata;
    logic                     r_cpu_hold;

    logic                     w_accept;
    logic [15:0]              w_len;
    logic [15:0]              w_count_inc;

    assign rx_ready    = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                         (r_state == S_DATA)   || (r_state == S_CSUM);
    assign w_accept    = rx_valid && rx_ready;
    assign w_len       = {rx_data, r_len[7:0]};
    assign w_count_inc = r_count + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_sum       <= '0;
            r_count     <= '0;
            r_wr_addr   <= BASE;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= BASE;
            r_mem_wdata <= '0;
            r_cpu_hold  <= 1'b1;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                S_IDLE, S_ERR: begin
                    if (start) begin
                        r_state    <= S_LEN_LO;
                        r_count    <= '0;
                        r_sum      <= '0;
                        r_wr_addr  <= BASE;
                        r_cpu_hold <= 1'b1;
                    end
                end
                S_LEN_LO: begin
                    if (w_accept) begin
                        r_len[7:0] <= rx_data;
                        r_state    <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (w_accept) begin
                        r_len <= w_len;
                        // Oversize frames are rejected before any byte reaches memory
                        if ({1'b0, w_len} > MAX_LEN)
                            r_state <= S_ERR;
                        else if (w_len == 16'd0)
                            r_state <= S_CSUM;
                        else
                            r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_wr_addr;
                        r_mem_wdata <= rx_data;
                        r_wr_addr   <= r_wr_addr + 1'b1;
                        r_sum       <= r_sum + rx_data;
                        r_count     <= w_count_inc;
                        if (w_count_inc == r_len)
                            r_state <= S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (w_accept)
                        r_state <= (rx_data == r_sum) ? S_DONE : S_ERR;
                end
                S_DONE: begin
                    r_state    <= S_IDLE;
                    r_cpu_hold <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign cpu_hold      = r_cpu_hold;
    assign busy          = (r_state != S_IDLE) && (r_state != S_ERR);
    assign load_done     = (r_state == S_DONE);
    assign load_err      = (r_state == S_ERR);
    assign bytes_written = r_count;

endmodule
